// File: rtl/residual_ctrl.sv
// Sequencer for the 8-wide residual datapath: walks 1..MAX_BLK 8x8 sub-blocks row by row.
// Latency: 3 cycles from a rd_addr to its matching out_valid/out_row/out_last tag.
// Backpressure: waits on dst_ready before issuing; once issuing, every row is pushed unconditionally.
module residual_ctrl #(
  parameter int ROWS    = 8,
  parameter int MAX_BLK = 4,
  parameter int ADDRW   = 5
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       blk_count,
  input  logic             dst_ready,
  output logic             rd_en,
  output logic [ADDRW-1:0] rd_addr,
  output logic             res_enable,
  output logic             out_valid,
  output logic [ADDRW-1:0] out_row,
  output logic             out_last,
  output logic             busy,
  output logic             done
);

  // One extra bit so the compare against total never wraps.
  localparam int AW1 = ADDRW + 1;
  localparam logic [AW1-1:0] ROWS_W = AW1'(ROWS);
  localparam logic [AW1-1:0] MAXB_W = AW1'(MAX_BLK);

  typedef enum logic [2:0] {IDLE, WAIT_DST, ISSUE, DRAIN, DONE} state_t;

  state_t           state, state_nxt;
  logic [AW1-1:0]   total;
  logic [AW1-1:0]   cnt;
  logic [1:0]       drain_cnt;
  logic [AW1-1:0]   blk_ext;
  logic [AW1-1:0]   req_total;
  logic             last_issue;

  // Pipeline tag stages mirroring the read buffer and the residual stage's registers.
  logic             v2;
  logic [ADDRW-1:0] a1, a2;
  logic             l1, l2;

  // Clamp the requested block count and convert it to a row total.
  always_comb begin
    blk_ext = AW1'(blk_count);
    if (blk_ext > MAXB_W) blk_ext = MAXB_W;
    req_total = blk_ext * ROWS_W;
  end

  assign last_issue = (cnt == total - AW1'(1));

  // State register plus request total, row counter and drain counter.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      total     <= '0;
      cnt       <= '0;
      drain_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && start) total <= req_total;
      // Counter returns to 0 after the last row so rd_addr idles at 0.
      if (state == ISSUE) cnt <= last_issue ? '0 : cnt + AW1'(1);
      if (state == DRAIN) drain_cnt <= drain_cnt + 2'd1;
      else                drain_cnt <= '0;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) begin
          if (blk_count == 3'd0) state_nxt = DONE;
          else if (dst_ready)    state_nxt = ISSUE;
          else                   state_nxt = WAIT_DST;
        end
      end
      WAIT_DST: if (dst_ready) state_nxt = ISSUE;
      ISSUE:    if (last_issue) state_nxt = DRAIN;
      DRAIN:    if (drain_cnt == 2'd2) state_nxt = DONE;
      DONE:     state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  assign rd_en   = (state == ISSUE);
  assign rd_addr = cnt[ADDRW-1:0];
  assign busy    = (state != IDLE);
  assign done    = (state == DONE);

  // Delay the read address, its qualifier and the last-row flag by three cycles.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      res_enable <= 1'b0;
      a1         <= '0;
      l1         <= 1'b0;
      v2         <= 1'b0;
      a2         <= '0;
      l2         <= 1'b0;
      out_valid  <= 1'b0;
      out_row    <= '0;
      out_last   <= 1'b0;
    end else begin
      res_enable <= rd_en;
      a1         <= rd_addr;
      l1         <= rd_en & last_issue;
      v2         <= res_enable;
      a2         <= a1;
      l2         <= l1;
      out_valid  <= v2;
      out_last   <= v2 & l2;
      // Row index only advances with a valid row; otherwise it holds.
      if (v2) out_row <= a2;
    end
  end

endmodule

// File: doc/residual_ctrl.md
# residual_ctrl

Sequencer for the 8-wide residual datapath in the FME pipeline. On a start request it walks 1..MAX_BLK 8x8 sub-blocks row by row: reading the original and best-candidate row buffers, driving the residual stage's `enable`, and tracking that stage's two-cycle register latency. It emits a per-row valid/row index/last tag aligned with the residual outputs and a block-level done pulse. It sits between the candidate-decision logic and the residual stage, with the transform/SATD consumer downstream.

## Interface
Parameters:
- `ROWS`, 8, rows per sub-block (one row = 8 pixels per cycle)
- `MAX_BLK`, 4, maximum sub-blocks per request
- `ADDRW`, 5, row-buffer address width; must satisfy 2^ADDRW >= MAX_BLK*ROWS

Ports:
- `clock`  in  1  single clock, rising edge
- `reset`  in  1  asynchronous, active-high reset
- `start`  in  1  request pulse; sampled only in IDLE
- `blk_count`  in  3  sub-blocks for this request; sampled with `start`
- `dst_ready`  in  1  downstream able to accept a full request; checked before issuing
- `rd_en`  out  1  read strobe to original and candidate row buffers (1-cycle read latency)
- `rd_addr`  out  ADDRW  row address, 0..total-1
- `res_enable`  out  1  drives the residual stage `enable`
- `out_valid`  out  1  residual stage outputs hold a new row this cycle
- `out_row`  out  ADDRW  row index of the row currently on the residual outputs
- `out_last`  out  1  qualifies the final row of the request
- `busy`  out  1  request in progress
- `done`  out  1  one-cycle completion pulse

## Operation
- States: IDLE, WAIT_DST, ISSUE, DRAIN, DONE.
- IDLE: when `start`=1, latch total = clamp(`blk_count`, MAX_BLK) * ROWS.
  - If `blk_count`=0, go to DONE. No reads are issued.
  - Otherwise, if `dst_ready`=1 go to ISSUE, else go to WAIT_DST.
- WAIT_DST: hold until `dst_ready`=1, then go to ISSUE. `dst_ready` is ignored once ISSUE is entered; the consumer must absorb every row of the request.
- ISSUE: `rd_en`=1 every cycle. `rd_addr` counts 0..total-1 with no gaps. After the cycle with `rd_addr`=total-1, go to DRAIN.
- DRAIN: stay 3 cycles while the pipeline empties, then go to DONE.
- DONE: `done`=1 for one cycle, then return to IDLE.
- Pipeline tags:
  - `res_enable` = `rd_en` registered once.
  - `out_valid` = `res_enable` delayed 2 cycles, matching the stage's input register plus its internal enable-gated output register.
  - `out_row` = `rd_addr` delayed 3 cycles, together with its `rd_en` qualifier.
  - `out_last` = (`rd_addr`==total-1) delayed 3 cycles; it is 1 only when `out_valid`=1.
  - `out_row` holds its last value when `out_valid`=0.
- `busy`=1 in every state except IDLE.
- `start` while `busy`=1 is ignored; it is not queued.
- `blk_count` > MAX_BLK is clamped to MAX_BLK.
- Counter and total width is ADDRW+1, so the compare against total never wraps.

## Timing
- Reset value of every output is 0. The state is IDLE. The residual stage shares `reset`, so a reset mid-request discards all in-flight rows and no `done` is produced. The first `start` is accepted on the first rising edge after `reset` deasserts.
- Let S be the cycle in which `start` is sampled in IDLE with `dst_ready`=1. Then:
  - `busy` rises at S+1.
  - `rd_en` is high at S+1..S+N, where N = total.
  - `res_enable` is high at S+2..S+N+1.
  - `out_valid` is high at S+4..S+N+3.
  - `out_last` is high at S+N+3.
  - `done` is high at S+N+4.
  - `busy` falls at S+N+5, and a new `start` is accepted in that cycle.
- Latency is 3 cycles from a `rd_addr` to its matching `out_valid`.
- With `dst_ready` low at S, every ISSUE-relative time above shifts by the number of WAIT_DST cycles.
- For `blk_count`=0: `busy`=1 at S+1, `done`=1 at S+1, and `busy`=0 at S+2.

## Test plan
- `blk_count`=1, `dst_ready`=1, `start` at cycle 10 -> `rd_addr` 0..7 at cycles 11..18; `out_valid` at 14..21 with `out_row` 0..7; `out_last` at 21; `done` at 22. Residual values must match original − candidate for each row, including the negative case 0x00 − 0xFF = −255.
- `blk_count`=4 -> 32 contiguous reads at `rd_addr` 0..31; exactly 32 `out_valid` cycles; `out_last` only on `out_row`=31; exactly one `done` pulse.
- `dst_ready`=0 for 5 cycles after `start` -> `busy`=1 and `rd_en`=0 for those cycles; the first `rd_en` comes 1 cycle after `dst_ready` rises; the remaining timeline is shifted by 5 cycles.
- `start` pulsed during ISSUE and during DRAIN -> no effect: row count, `out_last` position and `done` timing are unchanged.
- `blk_count`=0 -> `done` one cycle after `start` with no `rd_en` pulse. `blk_count`=7 -> clamped to 32 rows.
- `reset` asserted while `rd_addr`=12 -> all outputs are 0 immediately, the block returns to IDLE with no `done`, and a fresh `blk_count`=1 request after reset completes with nominal timing.
